// File: rtl/hash_uart_tx.sv
// hash_uart_tx: UART 8N1 serializer that streams a wide hash, most significant
// byte first, each byte LSB first on the line. Optional idle-high gap bits
// follow every stop bit. An abort finishes the current frame through its stop
// bit and then stops. All outputs come straight from flops.
//
// state   | meaning
// S_IDLE  | line high, ready for a new hash
// S_START | start bit (low)
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit (high)
// S_GAP   | GAP_BITS idle-high bit times between frames
module hash_uart_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BYTES    = 16,
    parameter int GAP_BITS     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hash_valid,
    input  logic [8*NUM_BYTES-1:0] hash_data,
    input  logic                   abort,
    output logic                   hash_ready,
    output logic                   tx_serial,
    output logic                   busy,
    output logic [3:0]             byte_idx,
    output logic                   done,
    output logic                   aborted
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // The bit counter covers the 8 data bits and, reused, the gap bit times.
    localparam int BIT_W  = (GAP_BITS > 8) ? $clog2(GAP_BITS) : 3;
    localparam int HASH_W = 8 * NUM_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [BIT_W-1:0]    r_bit;
    logic [HASH_W-1:0]   r_shift;
    logic [3:0]          r_idx;
    logic                r_abort;
    logic                r_tx;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_aborted;

    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [HASH_W-1:0]   w_shift_nxt;
    logic [3:0]          w_idx_nxt;
    logic                w_abort_nxt;
    logic                w_tx_nxt;
    logic                w_done_nxt;
    logic                w_aborted_nxt;
    logic [7:0]          w_byte_nxt;
    logic                w_bit_end;
    logic                w_last;
    logic                w_abort_any;

    assign w_bit_end   = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_last      = (r_idx == 4'(NUM_BYTES - 1));
    assign w_abort_any = r_abort | abort;

    // Next-state, counter, shift-register and registered-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_idx_nxt     = r_idx;
        w_abort_nxt   = r_abort;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_tx_nxt      = 1'b1;
        w_byte_nxt    = 8'h00;

        if (r_state != S_IDLE) begin
            w_baud_nxt = w_bit_end ? '0 : r_baud + 1'b1;
            if (abort) begin
                w_abort_nxt = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (hash_valid) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = hash_data;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_abort_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == BIT_W'(7)) begin
                        w_state_nxt = S_STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_bit_nxt = '0;
                    // An abort on the final byte is ignored: the hash completes normally.
                    if (!w_last && w_abort_any) begin
                        w_state_nxt   = S_IDLE;
                        w_idx_nxt     = '0;
                        w_abort_nxt   = 1'b0;
                        w_aborted_nxt = 1'b1;
                    end else if (GAP_BITS != 0) begin
                        w_state_nxt = S_GAP;
                    end else if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_abort_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_START;
                        w_idx_nxt   = r_idx + 1'b1;
                        w_shift_nxt = r_shift << 8;
                    end
                end
            end
            S_GAP: begin
                if (!w_last && w_abort_any) begin
                    w_state_nxt   = S_IDLE;
                    w_idx_nxt     = '0;
                    w_bit_nxt     = '0;
                    w_baud_nxt    = '0;
                    w_abort_nxt   = 1'b0;
                    w_aborted_nxt = 1'b1;
                end else if (w_bit_end) begin
                    if (r_bit == BIT_W'(GAP_BITS - 1)) begin
                        w_bit_nxt = '0;
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                            w_idx_nxt   = '0;
                            w_abort_nxt = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_START;
                            w_idx_nxt   = r_idx + 1'b1;
                            w_shift_nxt = r_shift << 8;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The line flop is loaded with the level belonging to the next cycle.
        w_byte_nxt = w_shift_nxt[HASH_W-1 -: 8];
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_byte_nxt[w_bit_nxt[2:0]];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_abort   <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_idx     <= w_idx_nxt;
            r_abort   <= w_abort_nxt;
            r_tx      <= w_tx_nxt;
            r_ready   <= (w_state_nxt == S_IDLE);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    assign hash_ready = r_ready;
    assign tx_serial  = r_tx;
    assign busy       = r_busy;
    assign byte_idx   = r_idx;
    assign done       = r_done;
    assign aborted    = r_aborted;

endmodule

// File: tb/tb_hash_uart_tx.sv
// tb_hash_uart_tx: directed bench for hash_uart_tx. Instance A has one gap
// bit, instance B has none. A UART decoder per instance checks every frame
// against a queue of expected bytes filled when a hash is accepted.
module tb_hash_uart_tx;

    localparam logic [127:0] H1 = 128'h8846F7EAEE8FB117AD06BDD830B7586C;
    localparam logic [127:0] H2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] H3 = 128'hA5C33C5A00FF817E6996F00F12345678;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vA = 1'b0, abA = 1'b0, rdyA, txA, busyA, doneA, abdA;
    logic [127:0] dA = '0;
    logic [3:0]   idxA;
    logic         vB = 1'b0, abB = 1'b0, rdyB, txB, busyB, doneB, abdB;
    logic [127:0] dB = '0;
    logic [3:0]   idxB;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] qA[$];
    logic [7:0] qB[$];

    hash_uart_tx #(.CLKS_PER_BIT(10), .NUM_BYTES(16), .GAP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .hash_valid(vA), .hash_data(dA), .abort(abA),
        .hash_ready(rdyA), .tx_serial(txA), .busy(busyA), .byte_idx(idxA),
        .done(doneA), .aborted(abdA)
    );

    hash_uart_tx #(.CLKS_PER_BIT(10), .NUM_BYTES(16), .GAP_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .hash_valid(vB), .hash_data(dB), .abort(abB),
        .hash_ready(rdyB), .tx_serial(txB), .busy(busyB), .byte_idx(idxB),
        .done(doneB), .aborted(abdB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART receiver model: detects a falling edge, samples mid-bit.
    bit         m_act[2];
    int         m_cnt[2];
    logic       m_prev[2];
    logic [7:0] m_byte[2];
    logic [7:0] m_exp;
    logic       m_t;

    // Decode both lines each falling clock edge and score completed frames.
    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            m_t = (ch == 0) ? txA : txB;
            if (rst) begin
                m_act[ch]  = 1'b0;
                m_prev[ch] = 1'b1;
            end else if (!m_act[ch]) begin
                if (m_prev[ch] === 1'b1 && m_t === 1'b0) begin
                    m_act[ch] = 1'b1;
                    m_cnt[ch] = 0;
                end
                m_prev[ch] = m_t;
            end else begin
                m_cnt[ch]++;
                if (m_cnt[ch] == 5) begin
                    chk("rx_start_bit", m_t, 1'b0);
                end else if (m_cnt[ch] >= 15 && m_cnt[ch] <= 85 && (m_cnt[ch] % 10) == 5) begin
                    m_byte[ch][(m_cnt[ch] - 15) / 10] = m_t;
                end else if (m_cnt[ch] == 95) begin
                    chk("rx_stop_bit", m_t, 1'b1);
                    if (ch == 0) begin
                        chk("rx_expected_frame_a", qA.size() != 0, 1'b1);
                        m_exp = (qA.size() != 0) ? qA.pop_front() : 8'hxx;
                    end else begin
                        chk("rx_expected_frame_b", qB.size() != 0, 1'b1);
                        m_exp = (qB.size() != 0) ? qB.pop_front() : 8'hxx;
                    end
                    chk("rx_byte", m_byte[ch], m_exp);
                    m_act[ch] = 1'b0;
                end
                m_prev[ch] = m_t;
            end
        end
    end

    // Send one hash on A and follow it cycle by cycle until done/aborted/reset.
    task automatic send_a(input logic [127:0] h, input bit frame0, input bit disturb,
                          input int abort_c, input int rst_c,
                          output int done_c, output int ab_c);
        int         c;
        int         k;
        bit         was_rst;
        logic       expb;
        logic [7:0] byte0;
        done_c  = 0;
        ab_c    = 0;
        was_rst = 1'b0;
        byte0   = h[127:120];
        @(negedge clk);
        vA = 1'b1;
        dA = h;
        @(posedge clk);
        for (int i = 0; i < 16; i++) qA.push_back(h[127 - 8*i -: 8]);
        #1;
        vA = 1'b0;
        c  = 0;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                chk("ready_low_after_accept", rdyA, 1'b0);
                chk("busy_high_after_accept", busyA, 1'b1);
            end
            if (frame0 && c <= 110) begin
                k    = (c - 1) / 10;
                expb = (k == 0) ? 1'b0 : (k <= 8) ? byte0[k-1] : 1'b1;
                chk($sformatf("frame0_cycle%0d", c), txA, expb);
            end
            if (c % 110 == 5) chk("byte_idx", idxA, c / 110);
            if (doneA === 1'b1 || abdA === 1'b1) begin
                chk("done_aborted_exclusive", doneA & abdA, 1'b0);
                if (doneA === 1'b1) done_c = c;
                if (abdA === 1'b1) ab_c = c;
                chk("ready_at_end", rdyA, 1'b1);
                chk("idx_zero_at_end", idxA, 4'd0);
                break;
            end
            if (c == rst_c) begin
                chk("line_low_before_reset", txA, 1'b0);
                #2 rst = 1'b1;
                #1;
                chk("rst_async_tx", txA, 1'b1);
                chk("rst_async_outs", {rdyA, busyA, idxA, doneA, abdA}, 8'b1_0_0000_0_0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                qA.delete();
                was_rst = 1'b1;
                break;
            end
            abA = (c == abort_c);
            if (disturb) begin
                vA = 1'($urandom_range(0, 1));
                dA = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        vA  = 1'b0;
        abA = 1'b0;
        chk("finished_in_budget", c < 3000, 1'b1);
        if (!was_rst) begin
            @(negedge clk);
            chk("end_pulse_single", {doneA, abdA}, 2'b00);
        end
    endtask

    initial begin
        int dc;
        int ac;
        int c;
        int zeros;
        logic prevtx;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_a", {txA, rdyA, busyA, idxA, doneA, abdA}, 9'b1_1_0_0000_0_0);
        chk("reset_b", {txB, rdyB, busyB, idxB, doneB, abdB}, 9'b1_1_0_0000_0_0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Known hash: first frame bit-exact, done 1760 cycles after first start cycle
        send_a(H1, 1'b1, 1'b0, 0, 0, dc, ac);
        chk("done_latency", dc, 1 + 1760);
        chk("no_abort_pulse", ac, 0);
        repeat (5) @(negedge clk);

        // Abort in byte 3 data bit 4: byte 3 completes through stop, no byte 4
        send_a(H1, 1'b0, 1'b0, 384, 0, dc, ac);
        chk("abort_pulse_cycle", ac, 431);
        chk("abort_no_done", dc, 0);
        chk("abort_ready", rdyA, 1'b1);
        zeros = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txA !== 1'b1) zeros++;
        end
        chk("line_idle_after_abort", zeros, 0);
        chk("sb_bytes_left_after_abort", qA.size(), 12);
        qA.delete();

        // Reset during byte 7 data, then a normal hash from byte 0
        send_a(H1, 1'b0, 1'b0, 0, 812, dc, ac);
        chk("rst_no_done", dc, 0);
        chk("rst_no_abort", ac, 0);
        @(negedge clk);
        chk("post_rst_outs", {txA, rdyA, busyA, idxA, doneA, abdA}, 9'b1_1_0_0000_0_0);
        send_a(H2, 1'b1, 1'b0, 0, 0, dc, ac);
        chk("post_rst_done_latency", dc, 1 + 1760);

        // Random hash_valid/hash_data activity while busy has no effect
        send_a(H3, 1'b0, 1'b1, 0, 0, dc, ac);
        chk("disturbed_done_latency", dc, 1 + 1760);
        chk("disturbed_no_abort", ac, 0);
        repeat (5) @(negedge clk);
        chk("disturbed_sb_empty", qA.size(), 0);

        // Back-to-back hashes on B (no gap bits), valid held high
        @(negedge clk);
        vB = 1'b1;
        dB = H2;
        @(posedge clk);
        for (int i = 0; i < 16; i++) qB.push_back(H2[127 - 8*i -: 8]);
        #1;
        dB = H3;
        c = 0;
        prevtx = 1'b0;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1600) prevtx = txB;
            if (doneB === 1'b1) break;
        end
        chk("b_done_latency", c, 1 + 1600);
        chk("b_stop_before_done", prevtx, 1'b1);
        chk("b_done_cycle_line_ready", {txB, rdyB, abdB}, 3'b110);
        for (int i = 0; i < 16; i++) qB.push_back(H3[127 - 8*i -: 8]);
        @(negedge clk);
        chk("b_second_start_bit", txB, 1'b0);
        chk("b_second_accepted", {rdyB, busyB}, 2'b01);
        vB = 1'b0;
        c = 1;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            if (doneB === 1'b1) break;
        end
        chk("b_second_done_latency", c, 1 + 1600);
        repeat (5) @(negedge clk);
        chk("b_sb_empty", qB.size(), 0);
        chk("a_sb_empty", qA.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
